foreground_fetch: RTL

Fixed-latency foreground pixel fetch stage sitting directly upstream of the pipeline's foreground input. It accepts signed foreground coordinate requests from the pipeline, bounds-checks them against the stored frame, and converts in-bounds ones to linear SRAM read addresses. It returns either a pixel or a skip exactly `FOREGROUND_FETCH_CYCLE_DELAY` cycles after each request, so the pipeline's fixed-delay assumption always holds.

---
 rtl/foreground_fetch.sv | 124 ++++++++++++
 1 files changed

// File: rtl/foreground_fetch.sv
// Fixed-latency foreground pixel fetch: bounds-checks signed coordinate requests,
// issues SRAM reads for in-bounds ones, and returns pixel or skip after a constant delay.
module foreground_fetch #(
  parameter int R_WIDTH                      = 5,
  parameter int G_WIDTH                      = 6,
  parameter int B_WIDTH                      = 5,
  parameter int PRECISION                    = 11,
  parameter int FG_WIDTH                     = 800,
  parameter int FG_HEIGHT                    = 600,
  parameter int ADDR_WIDTH                   = 19,
  parameter int SRAM_READ_LATENCY            = 2,
  parameter int FOREGROUND_FETCH_CYCLE_DELAY = 5
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic signed [PRECISION:0]             fg_pixel_request_x,
  input  logic signed [PRECISION:0]             fg_pixel_request_y,
  input  logic                                  fg_pixel_request_active,
  output logic [ADDR_WIDTH-1:0]                 sram_addr,
  output logic                                  sram_read_en,
  input  logic [R_WIDTH+G_WIDTH+B_WIDTH-1:0]    sram_data_in,
  output logic [R_WIDTH+G_WIDTH+B_WIDTH-1:0]    fg_pixel_in,
  output logic                                  fg_pixel_skip,
  output logic                                  fg_pixel_ready
);

  localparam int PIXEL_SIZE    = R_WIDTH + G_WIDTH + B_WIDTH;
  localparam int TAG_STAGES    = FOREGROUND_FETCH_CYCLE_DELAY - 1;
  localparam int CAPTURE_STAGE = SRAM_READ_LATENCY + 1;
  localparam int DATA_STAGES   = FOREGROUND_FETCH_CYCLE_DELAY - SRAM_READ_LATENCY - 2;

  // The response slot must lie after the SRAM data arrives, or the delay cannot be met.
  generate
    if (FOREGROUND_FETCH_CYCLE_DELAY < SRAM_READ_LATENCY + 2) begin : g_badDelay
      $error("foreground_fetch: FOREGROUND_FETCH_CYCLE_DELAY must be >= SRAM_READ_LATENCY + 2");
    end
  endgenerate

  logic [31:0]            w_xMag;
  logic [31:0]            w_yMag;
  logic                   w_xInBounds;
  logic                   w_yInBounds;
  logic                   w_inBounds;
  logic [63:0]            w_linearAddr;
  logic [PIXEL_SIZE-1:0]  w_captured;
  logic [PIXEL_SIZE-1:0]  w_dataToOut;

  logic [TAG_STAGES:1]    r_tagValid;
  logic [TAG_STAGES:1]    r_tagSkip;

  // A set sign bit means a negative coordinate, which is always outside the frame.
  assign w_xMag       = {{(31 - PRECISION){1'b0}}, fg_pixel_request_x};
  assign w_yMag       = {{(31 - PRECISION){1'b0}}, fg_pixel_request_y};
  assign w_xInBounds  = !fg_pixel_request_x[PRECISION] && (w_xMag < 32'(FG_WIDTH));
  assign w_yInBounds  = !fg_pixel_request_y[PRECISION] && (w_yMag < 32'(FG_HEIGHT));
  assign w_inBounds   = w_xInBounds && w_yInBounds;
  assign w_linearAddr = (64'(w_yMag) * 64'(FG_WIDTH)) + 64'(w_xMag);

  always_ff @(posedge clk) begin
    if (rst) begin
      sram_addr    <= '0;
      sram_read_en <= 1'b0;
    end else begin
      sram_read_en <= fg_pixel_request_active && w_inBounds;
      if (fg_pixel_request_active && w_inBounds) begin
        sram_addr <= ADDR_WIDTH'(w_linearAddr);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tagValid <= '0;
      r_tagSkip  <= '0;
    end else begin
      r_tagValid[1] <= fg_pixel_request_active;
      r_tagSkip[1]  <= fg_pixel_request_active && !w_inBounds;
      for (int k = 2; k <= TAG_STAGES; k++) begin
        r_tagValid[k] <= r_tagValid[k-1];
        r_tagSkip[k]  <= r_tagSkip[k-1];
      end
    end
  end

  // SRAM data lines up with the tag at the capture stage; unused slots carry zero.
  assign w_captured = (r_tagValid[CAPTURE_STAGE] && !r_tagSkip[CAPTURE_STAGE]) ?
                      sram_data_in : '0;

  generate
    if (DATA_STAGES == 0) begin : g_noDataDelay
      assign w_dataToOut = w_captured;
    end else begin : g_dataDelay
      logic [PIXEL_SIZE-1:0] r_dataPipe [DATA_STAGES];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int k = 0; k < DATA_STAGES; k++) begin
            r_dataPipe[k] <= '0;
          end
        end else begin
          r_dataPipe[0] <= w_captured;
          for (int k = 1; k < DATA_STAGES; k++) begin
            r_dataPipe[k] <= r_dataPipe[k-1];
          end
        end
      end

      assign w_dataToOut = r_dataPipe[DATA_STAGES-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      fg_pixel_ready <= 1'b0;
      fg_pixel_skip  <= 1'b0;
      fg_pixel_in    <= '0;
    end else begin
      fg_pixel_ready <= r_tagValid[TAG_STAGES];
      fg_pixel_skip  <= r_tagSkip[TAG_STAGES];
      fg_pixel_in    <= (r_tagValid[TAG_STAGES] && !r_tagSkip[TAG_STAGES]) ? w_dataToOut : '0;
    end
  end

endmodule
